// File: rtl/rv32i_defs.sv
// RV32I encoding definitions shared by the instruction encoder and its immediate packer.
package rv32i_defs;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned FUNCT7_W = 7;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned FMT_W    = 3;
    localparam int unsigned HI_W     = 20;
    localparam int unsigned LO_W     = 5;

    // Instruction formats; encodings 6 and 7 are illegal.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } instr_fmt_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // True for the immediate-shift forms that carry funct7 in [31:25].
    function automatic logic is_shift_imm(input logic [6:0] opcode, input logic [2:0] funct_3);
        return (opcode == OP_I) && ((funct_3 == 3'b001) || (funct_3 == 3'b101));
    endfunction

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// Scatters a byte-offset immediate into the instruction bit positions of each format.
// hi maps to instr[31:12], lo maps to instr[11:7].
// Optional macro IMM_RANGE_CHECK_EN: flag immediates that do not fit their format.
module imm_packer
    import rv32i_defs::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    output logic [19:0] hi,
    output logic [4:0]  lo,
    output logic        range_err
);

    // Per-format bit scatter; unused positions stay zero.
    always_comb begin
        hi = '0;
        lo = '0;
        case (instr_fmt_t'(fmt))
            FMT_I: hi = {imm[11:0], 8'b0};
            FMT_S: begin
                hi = {imm[11:5], 13'b0};
                lo = imm[4:0];
            end
            FMT_B: begin
                hi = {imm[12], imm[10:5], 13'b0};
                lo = {imm[4:1], imm[11]};
            end
            FMT_U: hi = imm[31:12];
            FMT_J: hi = {imm[20], imm[10:1], imm[11], imm[19:12]};
            default: begin
                hi = '0;
                lo = '0;
            end
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Immediate must be the sign extension of the field width (and even for branches/jumps).
    always_comb begin
        range_err = 1'b0;
        case (instr_fmt_t'(fmt))
            FMT_I, FMT_S: range_err = (imm[31:11] != {21{imm[11]}});
            FMT_B:        range_err = (imm[31:12] != {20{imm[12]}}) || imm[0];
            FMT_J:        range_err = (imm[31:20] != {12{imm[20]}}) || imm[0];
            FMT_U:        range_err = (imm[11:0] != 12'h000);
            default:      range_err = 1'b0;
        endcase
    end
`else
    // Immediates are silently truncated.
    assign range_err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder with a single registered valid/ready output stage
// and a byte-address counter that reloads BASE_ADDR after each last word.
// Optional macro IMM_RANGE_CHECK_EN: out-of-range immediates also set err.
module instr_encoder
    import rv32i_defs::*;
#(
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [2:0]        in_funct_3,
    input  logic [6:0]        in_funct_7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              err
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    logic [19:0] imm_hi;
    logic [4:0]  imm_lo;
    logic        imm_err;
    logic [31:0] word_c;
    logic        word_err_c;
    logic        accept;
    logic        out_hs;

    imm_packer u_imm_packer (
        .fmt       (in_fmt),
        .imm       (in_imm),
        .hi        (imm_hi),
        .lo        (imm_lo),
        .range_err (imm_err)
    );

    // The output register can take a word when empty or when it is being drained.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    // Assemble the instruction word from the request fields.
    always_comb begin
        word_c     = NOP_INSTR;
        word_err_c = 1'b0;
        case (instr_fmt_t'(in_fmt))
            FMT_R: word_c = {in_funct_7, in_rs2, in_rs1, in_funct_3, in_rd, in_opcode};
            FMT_I: begin
                if (is_shift_imm(in_opcode, in_funct_3)) begin
                    word_c = {in_funct_7, in_imm[4:0], in_rs1, in_funct_3, in_rd, in_opcode};
                end else begin
                    word_c = {imm_hi[19:8], in_rs1, in_funct_3, in_rd, in_opcode};
                end
                word_err_c = imm_err;
            end
            FMT_S, FMT_B: begin
                word_c     = {imm_hi[19:13], in_rs2, in_rs1, in_funct_3, imm_lo, in_opcode};
                word_err_c = imm_err;
            end
            FMT_U, FMT_J: begin
                word_c     = {imm_hi, in_rd, in_opcode};
                word_err_c = imm_err;
            end
            default: begin
                word_c     = NOP_INSTR;
                word_err_c = 1'b1;
            end
        endcase
    end

    // Output register: load on accept, empty on a handshake with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= word_c;
            out_last  <= in_last;
        end else if (out_hs) begin
            out_valid <= 1'b0;
        end
    end

    // Address counter advances per handshake and restarts after the last word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_addr <= BASE_ADDR;
        end else if (out_hs) begin
            out_addr <= out_last ? BASE_ADDR : out_addr + ADDR_STEP;
        end
    end

    // Sticky error, set when a flagged word is loaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (accept && word_err_c) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table-driven encodings plus handshake,
// address-wrap, illegal-format and reset corner cases.
module tb_instr_encoder;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    logic        clk;
    logic        rst_n;

    logic        m_in_valid, m_in_ready, m_in_last;
    logic [2:0]  m_fmt, m_f3;
    logic [6:0]  m_op, m_f7;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [31:0] m_imm;
    logic        m_out_valid, m_out_ready, m_out_last, m_err;
    logic [31:0] m_out_instr, m_out_addr;

    logic        w_in_valid, w_in_ready, w_in_last;
    logic [2:0]  w_fmt, w_f3;
    logic [6:0]  w_op, w_f7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [31:0] w_imm;
    logic        w_out_valid, w_out_ready, w_out_last, w_err;
    logic [31:0] w_out_instr;
    logic [3:0]  w_out_addr;

    int total = 0;
    int bad   = 0;
    vec_t tbl[10];

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_fmt(m_fmt), .in_opcode(m_op), .in_funct_3(m_f3), .in_funct_7(m_f7),
        .in_rd(m_rd), .in_rs1(m_rs1), .in_rs2(m_rs2), .in_imm(m_imm), .in_last(m_in_last),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out_instr(m_out_instr),
        .out_addr(m_out_addr), .out_last(m_out_last), .err(m_err)
    );

    instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_fmt(w_fmt), .in_opcode(w_op), .in_funct_3(w_f3), .in_funct_7(w_f7),
        .in_rd(w_rd), .in_rs1(w_rs1), .in_rs2(w_rs2), .in_imm(w_imm), .in_last(w_in_last),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_instr(w_out_instr),
        .out_addr(w_out_addr), .out_last(w_out_last), .err(w_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm, input logic [31:0] exp);
        vec_t v;
        v.fmt = fmt; v.op = op; v.f3 = f3; v.f7 = f7;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive_m(input vec_t v, input logic last);
        m_in_valid = 1'b1;
        m_fmt = v.fmt; m_op = v.op; m_f3 = v.f3; m_f7 = v.f7;
        m_rd = v.rd; m_rs1 = v.rs1; m_rs2 = v.rs2; m_imm = v.imm;
        m_in_last = last;
    endtask

    task automatic drive_w(input vec_t v, input logic last);
        w_in_valid = 1'b1;
        w_fmt = v.fmt; w_op = v.op; w_f3 = v.f3; w_f7 = v.f7;
        w_rd = v.rd; w_rs1 = v.rs1; w_rs2 = v.rs2; w_imm = v.imm;
        w_in_last = last;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t ill;
        vec_t big;

        tbl[0] = mk(3'd0, 7'b0110011, 3'd0, 7'h00, 5'd3,  5'd1,  5'd2,  32'hDEAD_BEEF, 32'h002081B3);
        tbl[1] = mk(3'd1, 7'b0010011, 3'd0, 7'h7F, 5'd1,  5'd0,  5'd0,  32'hFFFF_FFFF, 32'hFFF00093);
        tbl[2] = mk(3'd2, 7'b0100011, 3'd2, 7'h00, 5'd31, 5'd1,  5'd2,  32'h0000_0008, 32'h0020A423);
        tbl[3] = mk(3'd3, 7'b1100011, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'hFFFF_FFFC, 32'hFE000EE3);
        tbl[4] = mk(3'd5, 7'b1101111, 3'd7, 7'h7F, 5'd1,  5'd31, 5'd31, 32'h0000_0800, 32'h001000EF);
        tbl[5] = mk(3'd4, 7'b0110111, 3'd0, 7'h00, 5'd5,  5'd0,  5'd0,  32'h1234_5000, 32'h123452B7);
        tbl[6] = mk(3'd1, 7'b0010011, 3'd1, 7'h00, 5'd1,  5'd2,  5'd0,  32'h0000_0003, 32'h00311093);
        tbl[7] = mk(3'd1, 7'b0010011, 3'd5, 7'h20, 5'd1,  5'd2,  5'd0,  32'h0000_0005, 32'h40515093);
        tbl[8] = mk(3'd1, 7'b0000011, 3'd2, 7'h7F, 5'd4,  5'd3,  5'd0,  32'hFFFF_FFF8, 32'hFF81A203);
        tbl[9] = mk(3'd3, 7'b1100011, 3'd1, 7'h00, 5'd0,  5'd1,  5'd2,  32'h0000_0010, 32'h00209863);
        ill = mk(3'd7, 7'b0110011, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0, 32'h0000_0013);
        big = mk(3'd1, 7'b0010011, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 32'h80000093);

        rst_n = 1'b0;
        m_in_valid = 1'b0; m_out_ready = 1'b0; m_in_last = 1'b0;
        m_fmt = '0; m_op = '0; m_f3 = '0; m_f7 = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0; m_imm = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_in_last = 1'b0;
        w_fmt = '0; w_op = '0; w_f3 = '0; w_f7 = '0; w_rd = '0; w_rs1 = '0; w_rs2 = '0; w_imm = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(m_out_valid), 32'd0);
        chk("rst_instr", m_out_instr, 32'h0);
        chk("rst_addr", m_out_addr, 32'h0);
        chk("rst_last", 32'(m_out_last), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_in_ready", 32'(m_in_ready), 32'd1);
        chk("rst_w_addr", 32'(w_out_addr), 32'hC);
        @(negedge clk);
        rst_n = 1'b1;

        // Encoding table at full throughput
        m_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive_m(tbl[i], 1'b0);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid", i), 32'(m_out_valid), 32'd1);
            chk($sformatf("tbl%0d_instr", i), m_out_instr, tbl[i].exp);
            chk($sformatf("tbl%0d_addr", i), m_out_addr, 32'(i * 4));
            chk($sformatf("tbl%0d_err", i), 32'(m_err), 32'd0);
        end
        @(negedge clk);
        m_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_valid", 32'(m_out_valid), 32'd0);
        chk("drain_addr", m_out_addr, 32'd40);

        // Backpressure with three queued words
        pulse_reset();
        m_out_ready = 1'b0;
        drive_m(tbl[0], 1'b0);
        @(posedge clk);
        #1;
        chk("bp_first_instr", m_out_instr, tbl[0].exp);
        @(negedge clk);
        drive_m(tbl[1], 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_in_ready", k), 32'(m_in_ready), 32'd0);
            chk($sformatf("bp%0d_valid", k), 32'(m_out_valid), 32'd1);
            chk($sformatf("bp%0d_instr", k), m_out_instr, tbl[0].exp);
            chk($sformatf("bp%0d_addr", k), m_out_addr, 32'h0);
        end
        @(negedge clk);
        m_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_w1_instr", m_out_instr, tbl[1].exp);
        chk("bp_w1_addr", m_out_addr, 32'h4);
        chk("bp_w1_in_ready", 32'(m_in_ready), 32'd1);
        @(negedge clk);
        drive_m(tbl[2], 1'b0);
        @(posedge clk);
        #1;
        chk("bp_w2_instr", m_out_instr, tbl[2].exp);
        chk("bp_w2_addr", m_out_addr, 32'h8);
        @(negedge clk);
        m_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_drain_valid", 32'(m_out_valid), 32'd0);

        // Narrow address wrap and reload after last
        w_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_w(tbl[i], (i == 1) ? 1'b1 : 1'b0);
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d_valid", i), 32'(w_out_valid), 32'd1);
            chk($sformatf("wrap%0d_instr", i), w_out_instr, tbl[i].exp);
            chk($sformatf("wrap%0d_addr", i), 32'(w_out_addr), (i == 0) ? 32'hC : (i == 1) ? 32'h0 : 32'hC);
            chk($sformatf("wrap%0d_last", i), 32'(w_out_last), (i == 1) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        w_in_valid = 1'b0;

        // Illegal format emits NOP and sets sticky err
        drive_m(ill, 1'b0);
        @(posedge clk);
        #1;
        chk("ill_instr", m_out_instr, 32'h0000_0013);
        chk("ill_err", 32'(m_err), 32'd1);
        @(negedge clk);
        drive_m(tbl[0], 1'b0);
        @(posedge clk);
        #1;
        chk("ill_next_instr", m_out_instr, tbl[0].exp);
        chk("ill_err_sticky", 32'(m_err), 32'd1);

        // Reset mid-stream drops the stalled word
        @(negedge clk);
        m_out_ready = 1'b0;
        drive_m(tbl[5], 1'b0);
        @(posedge clk);
        #1;
        chk("mid_valid_before", 32'(m_out_valid), 32'd1);
        @(negedge clk);
        m_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_out_valid), 32'd0);
        chk("mid_rst_addr", m_out_addr, 32'h0);
        chk("mid_rst_err", 32'(m_err), 32'd0);
        chk("mid_rst_instr", m_out_instr, 32'h0);
        chk("mid_rst_w_addr", 32'(w_out_addr), 32'hC);
        @(negedge clk);
        rst_n = 1'b1;

        // I-format immediate of 2048 is truncated; flagged only with range checking
        m_out_ready = 1'b1;
        @(negedge clk);
        drive_m(big, 1'b0);
        @(posedge clk);
        #1;
        chk("big_instr", m_out_instr, big.exp);
        chk("big_addr", m_out_addr, 32'h0);
`ifdef IMM_RANGE_CHECK_EN
        chk("big_err", 32'(m_err), 32'd1);
`else
        chk("big_err", 32'(m_err), 32'd0);
`endif
        @(negedge clk);
        m_in_valid = 1'b0;
        @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
